// File: rtl/shifter8_seq.sv
// shifter8_seq: 8-bit command-driven shift register, one bit per clock; optional rotates under SHIFTER8_ROTATE_EN
module shifter8_seq (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       op_valid,
    input  logic [2:0] op,
    input  logic [1:0] shamt,
    input  logic [7:0] d_in,
    output logic [7:0] q,
    output logic       busy,
    output logic       done
);
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_LSL  = 3'b010;
    localparam logic [2:0] OP_LSR  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
`ifdef SHIFTER8_ROTATE_EN
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
`endif
    state_t      state_q, state_d;
    logic [7:0]  q_q, q_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        is_shift;
    logic [7:0]  step;
`ifdef SHIFTER8_ROTATE_EN
    assign is_shift = op == OP_LSL || op == OP_LSR || op == OP_ASR || op == OP_ROL || op == OP_ROR;
    assign step = op_q == OP_LSL ? {q_q[6:0], 1'b0} :
                  op_q == OP_LSR ? {1'b0, q_q[7:1]} :
                  op_q == OP_ASR ? {q_q[7], q_q[7:1]} :
                  op_q == OP_ROL ? {q_q[6:0], q_q[7]} : {q_q[0], q_q[7:1]};
`else
    assign is_shift = op == OP_LSL || op == OP_LSR || op == OP_ASR;
    assign step = op_q == OP_LSL ? {q_q[6:0], 1'b0} :
                  op_q == OP_LSR ? {1'b0, q_q[7:1]} : {q_q[7], q_q[7:1]};
`endif
    // Next state: accept commands only in IDLE, then step once per clock until count runs out
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        op_d    = op_q;
        if (state_q == IDLE) begin
            if (op_valid && op == OP_LOAD) begin
                q_d    = d_in;
                done_d = 1'b1;
            end else if (op_valid && is_shift) begin
                if (shamt == 2'd0) begin
                    done_d = 1'b1;
                end else begin
                    op_d    = op;
                    cnt_d   = shamt;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
        end else begin
            q_d   = step;
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end
    // State and output registers; reset aborts any shift in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            q_q     <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= 2'd0;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end
    assign q    = q_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_shifter8_seq.sv
// tb_shifter8_seq: directed self-checking bench for shifter8_seq
module tb_shifter8_seq;
    logic       clk;
    logic       reset_n;
    logic       op_valid;
    logic [2:0] op;
    logic [1:0] shamt;
    logic [7:0] d_in;
    logic [7:0] q;
    logic       busy;
    logic       done;
    int vectors;
    int miscompares;

    shifter8_seq dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op),
        .shamt(shamt), .d_in(d_in), .q(q), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [1:0] s, input logic [7:0] d);
        @(negedge clk);
        op_valid = 1'b1;
        op = o;
        shamt = s;
        d_in = d;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op = 3'b000;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        op_valid = 1'b0;
        op = 3'b000;
        shamt = 2'd0;
        d_in = 8'h00;
        #12;
        vectors++;
        if ({q, busy, done} !== {8'h00, 2'b00}) begin
            miscompares++;
            $display("FAIL reset_initial: got q=%h busy=%b done=%b, expected q=00 busy=0 done=0", q, busy, done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        issue(3'b001, 2'd0, 8'hA5);
        tick();
        vectors++;
        if (q !== 8'hA5) begin
            miscompares++;
            $display("FAIL reset_preload: got q=%h, expected A5", q);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({q, busy, done} !== {8'h00, 2'b00}) begin
            miscompares++;
            $display("FAIL reset_async: got q=%h busy=%b done=%b, expected q=00 busy=0 done=0", q, busy, done);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_load();
        issue(3'b001, 2'd0, 8'h96);
        vectors++;
        if ({q, busy, done} !== {8'h96, 2'b01}) begin
            miscompares++;
            $display("FAIL load_edge: got q=%h busy=%b done=%b, expected q=96 busy=0 done=1", q, busy, done);
        end
        tick();
        vectors++;
        if ({q, busy, done} !== {8'h96, 2'b00}) begin
            miscompares++;
            $display("FAIL load_after: got q=%h busy=%b done=%b, expected q=96 busy=0 done=0", q, busy, done);
        end
    endtask

    task automatic test_shift(input string nm, input logic [2:0] o, input logic [1:0] n,
                              input logic [7:0] start, input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3);
        logic [7:0] e [3];
        logic [9:0] exp;
        e[0] = e1;
        e[1] = e2;
        e[2] = e3;
        issue(3'b001, 2'd0, start);
        vectors++;
        if ({q, busy, done} !== {start, 2'b01}) begin
            miscompares++;
            $display("FAIL %s_load: got q=%h busy=%b done=%b, expected q=%h busy=0 done=1", nm, q, busy, done, start);
        end
        issue(o, n, 8'hFF);
        vectors++;
        if ({q, busy, done} !== {start, 2'b10}) begin
            miscompares++;
            $display("FAIL %s_accept: got q=%h busy=%b done=%b, expected q=%h busy=1 done=0", nm, q, busy, done, start);
        end
        for (int i = 0; i < int'(n); i++) begin
            tick();
            exp = {e[i], (i == int'(n) - 1) ? 2'b01 : 2'b10};
            vectors++;
            if ({q, busy, done} !== exp) begin
                miscompares++;
                $display("FAIL %s_step%0d: got q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                         nm, i + 1, q, busy, done, exp[9:2], exp[1], exp[0]);
            end
        end
        tick();
        vectors++;
        if ({q, busy, done} !== {e[int'(n) - 1], 2'b00}) begin
            miscompares++;
            $display("FAIL %s_idle: got q=%h busy=%b done=%b, expected q=%h busy=0 done=0", nm, q, busy, done, e[int'(n) - 1]);
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h5A;
        exp_q[1] = 8'h2D;
        exp_q[2] = 8'h16;
        issue(3'b001, 2'd0, 8'hB4);
        issue(3'b011, 2'd3, 8'h00);
        issue(3'b001, 2'd1, 8'hFF);
        vectors++;
        if ({q, busy, done} !== {exp_q[0], 2'b10}) begin
            miscompares++;
            $display("FAIL ignore_step1: got q=%h busy=%b done=%b, expected q=5A busy=1 done=0", q, busy, done);
        end
        tick();
        vectors++;
        if ({q, busy, done} !== {exp_q[1], 2'b10}) begin
            miscompares++;
            $display("FAIL ignore_step2: got q=%h busy=%b done=%b, expected q=2D busy=1 done=0", q, busy, done);
        end
        tick();
        vectors++;
        if ({q, busy, done} !== {exp_q[2], 2'b01}) begin
            miscompares++;
            $display("FAIL ignore_final: got q=%h busy=%b done=%b, expected q=16 busy=0 done=1", q, busy, done);
        end
        issue(3'b001, 2'd0, 8'h77);
        vectors++;
        if ({q, busy, done} !== {8'h77, 2'b01}) begin
            miscompares++;
            $display("FAIL first_idle_load: got q=%h busy=%b done=%b, expected q=77 busy=0 done=1", q, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        op_valid = 1'b1;
        op = 3'b001;
        d_in = 8'h11;
        tick();
        vectors++;
        if ({q, busy, done} !== {8'h11, 2'b01}) begin
            miscompares++;
            $display("FAIL b2b_first: got q=%h busy=%b done=%b, expected q=11 busy=0 done=1", q, busy, done);
        end
        @(negedge clk);
        d_in = 8'h22;
        tick();
        vectors++;
        if ({q, busy, done} !== {8'h22, 2'b01}) begin
            miscompares++;
            $display("FAIL b2b_second: got q=%h busy=%b done=%b, expected q=22 busy=0 done=1", q, busy, done);
        end
        op_valid = 1'b0;
        op = 3'b000;
        tick();
        vectors++;
        if ({q, busy, done} !== {8'h22, 2'b00}) begin
            miscompares++;
            $display("FAIL b2b_after: got q=%h busy=%b done=%b, expected q=22 busy=0 done=0", q, busy, done);
        end
    endtask

    task automatic test_shamt0();
        issue(3'b001, 2'd0, 8'h3C);
        issue(3'b010, 2'd0, 8'h00);
        vectors++;
        if ({q, busy, done} !== {8'h3C, 2'b01}) begin
            miscompares++;
            $display("FAIL shamt0_edge: got q=%h busy=%b done=%b, expected q=3C busy=0 done=1", q, busy, done);
        end
        tick();
        vectors++;
        if ({q, busy, done} !== {8'h3C, 2'b00}) begin
            miscompares++;
            $display("FAIL shamt0_after: got q=%h busy=%b done=%b, expected q=3C busy=0 done=0", q, busy, done);
        end
    endtask

    task automatic test_reset_mid_shift();
        issue(3'b001, 2'd0, 8'h96);
        issue(3'b010, 2'd3, 8'h00);
        tick();
        vectors++;
        if ({q, busy, done} !== {8'h2C, 2'b10}) begin
            miscompares++;
            $display("FAIL midrst_step1: got q=%h busy=%b done=%b, expected q=2C busy=1 done=0", q, busy, done);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({q, busy, done} !== {8'h00, 2'b00}) begin
            miscompares++;
            $display("FAIL midrst_async: got q=%h busy=%b done=%b, expected q=00 busy=0 done=0", q, busy, done);
        end
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({q, busy, done} !== {8'h00, 2'b00}) begin
                miscompares++;
                $display("FAIL midrst_release%0d: got q=%h busy=%b done=%b, expected q=00 busy=0 done=0", i, q, busy, done);
            end
        end
    endtask

    task automatic test_ignored_op(input string nm, input logic [2:0] o, input logic [7:0] start);
        issue(3'b001, 2'd0, start);
        issue(o, 2'd2, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({q, busy, done} !== {start, 2'b00}) begin
                miscompares++;
                $display("FAIL %s_%0d: got q=%h busy=%b done=%b, expected q=%h busy=0 done=0", nm, i, q, busy, done, start);
            end
            tick();
        end
    endtask

    task automatic test_rotate();
`ifdef SHIFTER8_ROTATE_EN
        test_shift("rol1", 3'b101, 2'd1, 8'h81, 8'h03, 8'h00, 8'h00);
        test_shift("ror2", 3'b110, 2'd2, 8'h81, 8'hC0, 8'h60, 8'h00);
`else
        test_ignored_op("op101", 3'b101, 8'h81);
        test_ignored_op("op110", 3'b110, 8'h81);
`endif
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_load();
        test_shift("lsl3", 3'b010, 2'd3, 8'h96, 8'h2C, 8'h58, 8'hB0);
        test_shift("asr2", 3'b100, 2'd2, 8'h96, 8'hCB, 8'hE5, 8'h00);
        test_shift("lsr1", 3'b011, 2'd1, 8'h81, 8'h40, 8'h00, 8'h00);
        test_busy_ignore();
        test_back_to_back();
        test_shamt0();
        test_reset_mid_shift();
        test_ignored_op("op111", 3'b111, 8'h5A);
        test_ignored_op("nop", 3'b000, 8'hC3);
        test_rotate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
